mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one RAM port between a CPU
// requester and an I/O requester. One transaction at a time; reads wait
// RD_LAT cycles for RAM data and return it on the owner's rdata/rvalid.
module mem_port_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic              io_gnt,
  output logic              io_rvalid,
  output logic [DATA_W-1:0] io_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Number of WAIT cycles between ACCESS and CAPTURE (zero when RD_LAT is 1).
  localparam logic [2:0] WAIT_CYCLES = 3'(RD_LAT - 1);
  localparam logic       OWN_CPU     = 1'b0;
  localparam logic       OWN_IO      = 1'b1;

  state_t              state_r;
  state_t              state_s;
  logic [2:0]          wait_cnt_r;
  logic [2:0]          wait_cnt_s;
  // Winner of the most recent grant; doubles as the owner of the
  // transaction in flight, since only one transaction runs at a time.
  logic                last_owner_r;
  logic                we_r;
  logic                grant_s;
  logic                winner_s;
  logic                win_we_s;
  logic [ADDR_W-1:0]   win_addr_s;
  logic [DATA_W-1:0]   win_wdata_s;

  // Next-state logic: arbitration in IDLE, fixed-length sequencing elsewhere.
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    grant_s    = 1'b0;
    winner_s   = last_owner_r;
    case (state_r)
      IDLE: begin
        if (cpu_req && io_req) begin
          grant_s  = 1'b1;
          winner_s = ~last_owner_r;
        end else if (cpu_req) begin
          grant_s  = 1'b1;
          winner_s = OWN_CPU;
        end else if (io_req) begin
          grant_s  = 1'b1;
          winner_s = OWN_IO;
        end else begin
          grant_s  = 1'b0;
          winner_s = last_owner_r;
        end
        if (grant_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r) begin
          state_s = IDLE;
        end else if (WAIT_CYCLES != 3'd0) begin
          state_s    = WAIT;
          wait_cnt_s = WAIT_CYCLES;
        end else begin
          state_s = CAPTURE;
        end
      end
      WAIT: begin
        if (wait_cnt_r <= 3'd1) begin
          state_s    = CAPTURE;
          wait_cnt_s = 3'd0;
        end else begin
          state_s    = WAIT;
          wait_cnt_s = wait_cnt_r - 3'd1;
        end
      end
      CAPTURE: begin
        state_s = IDLE;
      end
      default: begin
        state_s    = IDLE;
        wait_cnt_s = 3'd0;
      end
    endcase
  end

  // Select the winning requester's command fields.
  always_comb begin
    if (winner_s == OWN_IO) begin
      win_we_s    = io_we;
      win_addr_s  = io_addr;
      win_wdata_s = io_wdata;
    end else begin
      win_we_s    = cpu_we;
      win_addr_s  = cpu_addr;
      win_wdata_s = cpu_wdata;
    end
  end

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      wait_cnt_r <= 3'd0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
    end
  end

  // Latch the winner's command; held stable until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_r <= OWN_IO;
      we_r         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else if (grant_s) begin
      last_owner_r <= winner_s;
      we_r         <= win_we_s;
      mem_addr     <= win_addr_s;
      mem_wdata    <= win_wdata_s;
    end
  end

  // Registered handshake pulses, write strobe and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_gnt    <= 1'b0;
      io_gnt     <= 1'b0;
      cpu_rvalid <= 1'b0;
      io_rvalid  <= 1'b0;
      mem_wren   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      cpu_gnt    <= grant_s && (winner_s == OWN_CPU);
      io_gnt     <= grant_s && (winner_s == OWN_IO);
      cpu_rvalid <= (state_r == CAPTURE) && (last_owner_r == OWN_CPU);
      io_rvalid  <= (state_r == CAPTURE) && (last_owner_r == OWN_IO);
      mem_wren   <= grant_s && win_we_s;
      busy       <= (state_s != IDLE);
    end
  end

  // Capture RAM read data into the owning requester's data register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_rdata <= '0;
      io_rdata  <= '0;
    end else if (state_r == CAPTURE) begin
      if (last_owner_r == OWN_CPU) begin
        cpu_rdata <= mem_rdata;
      end else begin
        io_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table of single
// transactions, hand-written multi-cycle sequences, and a scoreboard
// monitor that checks every grant and read return against queued
// expectations. A second instance exercises the RD_LAT=1 build.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid, mem_wren, busy;
  logic [15:0] cpu_rdata, io_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        d1_cpu_req, d1_cpu_we, d1_io_req, d1_io_we;
  logic [15:0] d1_cpu_addr, d1_cpu_wdata, d1_io_addr, d1_io_wdata;
  logic        d1_cpu_gnt, d1_cpu_rvalid, d1_io_gnt, d1_io_rvalid, d1_mem_wren, d1_busy;
  logic [15:0] d1_cpu_rdata, d1_io_rdata, d1_mem_addr, d1_mem_wdata, d1_mem_rdata;

  logic [15:0] pipe0, pipe1, d1_pipe;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        own_io;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic        own_io;
    logic [15:0] data;
  } rd_exp_t;

  typedef struct {
    logic        cpu_req;
    logic        io_req;
    logic        cpu_we;
    logic        io_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] io_addr;
    logic [15:0] io_wdata;
    logic        exp_io;
  } vec_t;

  gnt_exp_t gnt_q[$];
  rd_exp_t  rd_q[$];
  gnt_exp_t ge;
  rd_exp_t  re;
  vec_t     vecs[9];
  logic [15:0] cpu_m, io_m;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_addr(d1_cpu_addr), .cpu_wdata(d1_cpu_wdata),
    .cpu_gnt(d1_cpu_gnt), .cpu_rvalid(d1_cpu_rvalid), .cpu_rdata(d1_cpu_rdata),
    .io_req(d1_io_req), .io_we(d1_io_we), .io_addr(d1_io_addr), .io_wdata(d1_io_wdata),
    .io_gnt(d1_io_gnt), .io_rvalid(d1_io_rvalid), .io_rdata(d1_io_rdata),
    .mem_addr(d1_mem_addr), .mem_wdata(d1_mem_wdata), .mem_wren(d1_mem_wren),
    .mem_rdata(d1_mem_rdata), .busy(d1_busy)
  );

  // RAM contents as a function of address.
  function automatic logic [15:0] ram_f(input logic [15:0] a);
    return a ^ 16'h1214;
  endfunction

  // RAM model: data for the address presented in cycle N is valid in cycle N+latency.
  always @(posedge clk) begin
    pipe0   <= ram_f(mem_addr);
    pipe1   <= pipe0;
    d1_pipe <= ram_f(d1_mem_addr);
  end
  assign mem_rdata    = pipe1;
  assign d1_mem_rdata = d1_pipe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    cpu_m = 16'h0000;
    io_m  = 16'h0000;
  endtask

  // Scoreboard monitor: every grant and every read return must match the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_gnt || io_gnt) begin
        check("gnt_expected", 32'(gnt_q.size() != 0), 32'd1);
        if (gnt_q.size() != 0) begin
          ge = gnt_q.pop_front();
          check("gnt_owner", {30'd0, io_gnt, cpu_gnt}, {30'd0, ge.own_io, ~ge.own_io});
          check("gnt_wren", 32'(mem_wren), 32'(ge.we));
          check("gnt_addr", 32'(mem_addr), 32'(ge.addr));
          check("gnt_wdata", 32'(mem_wdata), 32'(ge.wdata));
        end
      end
      if (cpu_rvalid || io_rvalid) begin
        check("rvalid_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          re = rd_q.pop_front();
          check("rvalid_owner", {30'd0, io_rvalid, cpu_rvalid}, {30'd0, re.own_io, ~re.own_io});
          check("rvalid_data", 32'(re.own_io ? io_rdata : cpu_rdata), 32'(re.data));
        end
      end
    end
  end

  initial begin
    vec_t        v;
    logic        we;
    logic [15:0] addr, wdata;
    int          cycles;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0020, 16'h0000, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, 16'h3333, 16'h0400, 16'h4444, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h0500, 16'h5555, 16'h0600, 16'h6666, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h7777, 16'hAAAA, 16'h8888, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};

    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = 16'h0000; io_wdata  = 16'h0000;
    d1_cpu_req = 1'b0; d1_cpu_we = 1'b0; d1_cpu_addr = 16'h0000; d1_cpu_wdata = 16'h0000;
    d1_io_req  = 1'b0; d1_io_we  = 1'b0; d1_io_addr  = 16'h0000; d1_io_wdata  = 16'h0000;
    reset = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_pulses", {26'd0, cpu_gnt, io_gnt, cpu_rvalid, io_rvalid, mem_wren, busy}, 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_io_rdata", 32'(io_rdata), 32'd0);
    check("rst_d1_busy", 32'(d1_busy), 32'd0);
    reset = 1'b0;
    cpu_m = 16'h0000;
    io_m  = 16'h0000;

    // Table of single transactions, each started in IDLE
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      io_req  = v.io_req;  io_we  = v.io_we;  io_addr  = v.io_addr;  io_wdata  = v.io_wdata;
      we    = v.exp_io ? v.io_we    : v.cpu_we;
      addr  = v.exp_io ? v.io_addr  : v.cpu_addr;
      wdata = v.exp_io ? v.io_wdata : v.cpu_wdata;
      if (v.cpu_req || v.io_req) begin
        gnt_q.push_back('{v.exp_io, we, addr, wdata});
        if (!we) rd_q.push_back('{v.exp_io, ram_f(addr)});
        step();
        check("vec_cpu_gnt", 32'(cpu_gnt), 32'(!v.exp_io));
        check("vec_io_gnt", 32'(io_gnt), 32'(v.exp_io));
        check("vec_busy_access", 32'(busy), 32'd1);
        cpu_req = 1'b0;
        io_req  = 1'b0;
        cycles = 1;
        while (busy && cycles < 20) begin
          step();
          cycles++;
        end
        check("vec_cycles_to_idle", 32'(cycles), we ? 32'd2 : 32'(RD_LAT + 2));
        check("vec_owner_rvalid", 32'(v.exp_io ? io_rvalid : cpu_rvalid), 32'(!we));
        check("vec_other_rvalid", 32'(v.exp_io ? cpu_rvalid : io_rvalid), 32'd0);
        check("vec_wren_off", 32'(mem_wren), 32'd0);
        if (!we) begin
          if (v.exp_io) io_m = ram_f(addr);
          else          cpu_m = ram_f(addr);
        end
        check("vec_cpu_rdata", 32'(cpu_rdata), 32'(cpu_m));
        check("vec_io_rdata", 32'(io_rdata), 32'(io_m));
      end else begin
        for (int k = 0; k < 4; k++) begin
          step();
          check("idle_busy", 32'(busy), 32'd0);
        end
      end
    end

    // Request while busy: io_req rises during a CPU read's WAIT
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0C00; cpu_wdata = 16'h0000;
    gnt_q.push_back('{1'b0, 1'b0, 16'h0C00, 16'h0000});
    rd_q.push_back('{1'b0, ram_f(16'h0C00)});
    step();
    check("busyreq_cpu_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    step();
    io_req = 1'b1; io_we = 1'b1; io_addr = 16'h0D00; io_wdata = 16'hD00D;
    gnt_q.push_back('{1'b1, 1'b1, 16'h0D00, 16'hD00D});
    for (int c = 3; c <= 5; c++) begin
      step();
      check("busyreq_io_gnt", 32'(io_gnt), 32'(c == 5));
      if (c == 4) begin
        check("busyreq_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        cpu_m = ram_f(16'h0C00);
        check("busyreq_cpu_rdata", 32'(cpu_rdata), 32'(cpu_m));
      end
    end
    io_req = 1'b0;
    step();
    check("busyreq_done", 32'(busy), 32'd0);
    step();

    // RD_LAT=1 build: CAPTURE at cycle 2, rvalid at cycle 3
    d1_cpu_req = 1'b1; d1_cpu_we = 1'b0; d1_cpu_addr = 16'h0123;
    step();
    check("d1_gnt", 32'(d1_cpu_gnt), 32'd1);
    check("d1_busy_c1", 32'(d1_busy), 32'd1);
    d1_cpu_req = 1'b0;
    step();
    check("d1_busy_c2", 32'(d1_busy), 32'd1);
    check("d1_rvalid_c2", 32'(d1_cpu_rvalid), 32'd0);
    step();
    check("d1_busy_c3", 32'(d1_busy), 32'd0);
    check("d1_rvalid_c3", 32'(d1_cpu_rvalid), 32'd1);
    check("d1_rdata", 32'(d1_cpu_rdata), 32'(ram_f(16'h0123)));
    step();
    check("d1_rvalid_c4", 32'(d1_cpu_rvalid), 32'd0);

    // Reset mid-read: reset asserted during WAIT aborts with no rvalid
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0AAA; cpu_wdata = 16'h0000;
    gnt_q.push_back('{1'b0, 1'b0, 16'h0AAA, 16'h0000});
    step();
    check("rstmid_gnt", 32'(cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    step();
    check("rstmid_busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_m = 16'h0000;
    io_m  = 16'h0000;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rstmid_wren", 32'(mem_wren), 32'd0);
    check("rstmid_rdata", 32'(cpu_rdata), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rstmid_no_rvalid", 32'(cpu_rvalid | io_rvalid), 32'd0);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0E00; cpu_wdata = 16'hE0E0;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 16'h0F00; io_wdata  = 16'hF0F0;
    gnt_q.push_back('{1'b0, 1'b1, 16'h0E00, 16'hE0E0});
    step();
    check("rstmid_tie_cpu", 32'(cpu_gnt), 32'd1);
    check("rstmid_tie_io", 32'(io_gnt), 32'd0);
    cpu_req = 1'b0;
    io_req  = 1'b0;
    step();
    step();

    // Tie after reset with both requests held: CPU, IO, CPU, IO
    do_reset();
    gnt_q.push_back('{1'b0, 1'b1, 16'h0A00, 16'hA0A0});
    gnt_q.push_back('{1'b1, 1'b1, 16'h0B00, 16'hB0B0});
    gnt_q.push_back('{1'b0, 1'b1, 16'h0A00, 16'hA0A0});
    gnt_q.push_back('{1'b1, 1'b1, 16'h0B00, 16'hB0B0});
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0A00; cpu_wdata = 16'hA0A0;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 16'h0B00; io_wdata  = 16'hB0B0;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("tie_cpu_gnt", 32'(cpu_gnt), 32'(c == 1 || c == 5));
      check("tie_io_gnt", 32'(io_gnt), 32'(c == 3 || c == 7));
    end
    cpu_req = 1'b0;
    io_req  = 1'b0;
    step();
    step();
    check("tie_idle", 32'(busy), 32'd0);

    check("gnt_q_drained", 32'(gnt_q.size()), 32'd0);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
